// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter: each queued byte is handed over with a
// one-cycle tx_start pulse, then the feeder waits for the transmitter's busy handshake.
module uart_tx_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        flush,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic          wb_cnt_reg, wb_cnt_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          full_reg, empty_reg, overflow_reg;
    logic [7:0]    tx_data_reg;
    logic          push, pop;

    // A full FIFO drops the write even if a pop frees a slot in the same cycle.
    assign push = wr_en && !full_reg && !flush;

    always_comb begin
        state_next  = state_reg;
        wb_cnt_next = wb_cnt_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg && !tx_busy && !flush) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                wb_cnt_next = 1'b0;
                state_next  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never raises busy gets two cycles, then the byte counts as sent.
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wb_cnt_reg) begin
                    state_next = IDLE;
                end else begin
                    wb_cnt_next = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wb_cnt_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg  <= state_next;
            wb_cnt_reg <= wb_cnt_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end
            // tx_data only changes on a pop, so it holds through LAUNCH and both wait states.
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg];
            end
            count_reg    <= count_next;
            full_reg     <= (count_next == DEPTH_C);
            empty_reg    <= (count_next == '0);
            overflow_reg <= wr_en && full_reg && !flush;
        end
    end

    assign tx_start = (state_reg == LAUNCH);
    assign tx_data  = tx_data_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural transmitter drives tx_busy, a monitor logs every
// launched byte, and each scenario task compares the log against the bytes it expects.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          flush = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transmitter model: 0 = busy for busy_len cycles starting one cycle after tx_start,
    // 1 = busy tied low, 2 = busy held high (stalled).
    int   busy_mode = 1;
    int   busy_len = 1;
    int   busy_left = 0;
    bit   start_seen = 1'b0;
    logic prev_busy = 1'b0;

    logic [7:0] sent_q[$];
    int         start_q[$];
    int         max_count = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (busy_mode == 0) begin
            if (start_seen) begin
                start_seen = 1'b0;
                busy_left  = busy_len;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end
            tx_busy = (busy_left > 0);
        end else begin
            start_seen = 1'b0;
            busy_left  = 0;
            tx_busy    = (busy_mode == 2);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (tx_start === 1'b1) begin
                sent_q.push_back(tx_data);
                start_q.push_back(cyc);
                start_seen = 1'b1;
                checks++;
                if (prev_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL start_after_busy cyc=%0d prev tx_busy=%b required 0", cyc, prev_busy);
                end
            end
            if (int'(count) > max_count) max_count = int'(count);
        end
        prev_busy = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic clear_log;
        sent_q.delete();
        start_q.delete();
        max_count = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wr_en = 1'b0;
        flush = 1'b0;
        busy_mode = 1;
        tick(2);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rst = 1'b0;
        tick(2);
        clear_log();
        $display("test_reset done");
    endtask

    task automatic test_single;
        int w;
        busy_mode = 0;
        busy_len  = 870;
        tick(2);
        clear_log();
        w = cyc;
        write_byte(8'hA5);
        for (int i = 0; i < 10 && start_q.size() == 0; i++) tick(1);
        checks++;
        if (start_q.size() != 1) begin
            errors++;
            $display("FAIL single_start_seen got %0d starts want 1", start_q.size());
        end else begin
            checks++; if (start_q[0] != w + 2) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", start_q[0], w + 2); end
            checks++; if (sent_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", sent_q[0]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
        tick(400);
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", tx_data); end
        tick(480);
        checks++; if (start_q.size() != 1) begin errors++; $display("FAIL single_count got %0d starts want 1", start_q.size()); end
        $display("test_single launched %0d byte(s)", start_q.size());
    endtask

    task automatic test_burst;
        busy_mode = 2;
        tick(3);
        clear_log();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i + 1);
            tick(1);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL burst_full got %b want 1", full); end
        checks++; if (count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL burst_count got %0d want %0d", count, DEPTH); end
        wr_data = 8'hFF;
        tick(1);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow got %b want 1", overflow); end
        checks++; if (count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL burst_count_after_drop got %0d want %0d", count, DEPTH); end
        tick(1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow_width got %b want 0", overflow); end
        busy_len  = int'($urandom_range(1, 6));
        busy_mode = 0;
        tick(16 * (busy_len + 3) + 20);
        checks++; if (sent_q.size() != 16) begin errors++; $display("FAIL burst_sent_count got %0d want 16", sent_q.size()); end
        for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order idx %0d got %h want %h", i, sent_q[i], 8'(i + 1)); end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != busy_len + 3) begin
                errors++;
                $display("FAIL burst_gap idx %0d got %0d cycles want %0d", i, start_q[i] - start_q[i-1], busy_len + 3);
            end
        end
        $display("test_burst busy_len=%0d sent %0d byte(s)", busy_len, sent_q.size());
    endtask

    task automatic test_wrap;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        busy_len  = int'($urandom_range(1, 3));
        busy_mode = 0;
        tick(2);
        clear_log();
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            write_byte(d);
            tick(int'($urandom_range(8, 12)));
        end
        tick(100);
        checks++; if (sent_q.size() != 40) begin errors++; $display("FAIL wrap_sent_count got %0d want 40", sent_q.size()); end
        for (int i = 0; i < 40 && i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order idx %0d got %h want %h", i, sent_q[i], exp_q[i]); end
        end
        checks++; if (max_count > DEPTH) begin errors++; $display("FAIL wrap_max_count got %0d want <= %0d", max_count, DEPTH); end
        $display("test_wrap busy_len=%0d sent %0d byte(s)", busy_len, sent_q.size());
    endtask

    task automatic test_flush;
        logic [7:0] first;
        logic [7:0] d;
        busy_len  = 20;
        busy_mode = 0;
        tick(2);
        clear_log();
        first = 8'h00;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (i == 0) first = d;
            write_byte(d);
        end
        tick(1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        tick(1);
        flush = 1'b0;
        wr_en = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b want 0", overflow); end
        tick(60);
        checks++; if (sent_q.size() != 1) begin errors++; $display("FAIL flush_sent_count got %0d want 1", sent_q.size()); end
        if (sent_q.size() > 0) begin
            checks++; if (sent_q[0] !== first) begin errors++; $display("FAIL flush_inflight got %h want %h", sent_q[0], first); end
        end
        $display("test_flush sent %0d byte(s)", sent_q.size());
    endtask

    task automatic test_timeout;
        int w;
        logic [7:0] b2;
        busy_mode = 1;
        tick(2);
        clear_log();
        w  = cyc;
        b2 = 8'($urandom);
        write_byte(8'h3C);
        write_byte(b2);
        tick(2);
        checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL timeout_hold got %h want 3c", tx_data); end
        tick(10);
        checks++;
        if (start_q.size() != 2) begin
            errors++;
            $display("FAIL timeout_starts got %0d want 2", start_q.size());
        end else begin
            checks++; if (start_q[0] != w + 2) begin errors++; $display("FAIL timeout_first got cycle %0d want %0d", start_q[0], w + 2); end
            checks++; if (start_q[1] != start_q[0] + 4) begin errors++; $display("FAIL timeout_relaunch got cycle %0d want %0d", start_q[1], start_q[0] + 4); end
            checks++; if (sent_q[0] !== 8'h3C) begin errors++; $display("FAIL timeout_data0 got %h want 3c", sent_q[0]); end
            checks++; if (sent_q[1] !== b2) begin errors++; $display("FAIL timeout_data1 got %h want %h", sent_q[1], b2); end
        end
        $display("test_timeout sent %0d byte(s)", sent_q.size());
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        busy_len  = 30;
        busy_mode = 0;
        tick(2);
        clear_log();
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        tick(6);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
        checks++; if (count !== '0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
        tick(2);
        rst = 1'b0;
        tick(60);
        checks++; if (sent_q.size() != 1) begin errors++; $display("FAIL mid_no_restart got %0d starts want 1", sent_q.size()); end
        d = 8'($urandom);
        write_byte(d);
        tick(40);
        checks++;
        if (sent_q.size() != 2) begin
            errors++;
            $display("FAIL mid_new_write got %0d starts want 2", sent_q.size());
        end else begin
            checks++; if (sent_q[1] !== d) begin errors++; $display("FAIL mid_new_data got %h want %h", sent_q[1], d); end
        end
        $display("test_reset_mid sent %0d byte(s)", sent_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
